// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - single-clock FIFO pointer/flag controller for an external dual-port RAM
// Optional almost_full/almost_empty ports are enabled by defining FIFO_ALMOST_FLAGS_EN.
module fifo_ptr_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              overflow,
  output logic              underflow
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic [PW-1:0] count_nxt;
  logic          full_nxt;
  logic          empty_nxt;

  // Accept decisions use only the registered flags, so the RAM strobes are glitch-free of the
  // pointer update in the same cycle.
  assign ram_we    = wr_req & ~full;
  assign ram_re    = rd_req & ~empty;
  assign ram_waddr = wr_ptr[ADDR_W-1:0];
  assign ram_raddr = rd_ptr[ADDR_W-1:0];

  always_comb begin
    wr_ptr_nxt = wr_ptr + PW'(ram_we);
    rd_ptr_nxt = rd_ptr + PW'(ram_re);
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    full_nxt   = (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]) &&
                 (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      wr_ptr_gray <= '0;
      rd_ptr_gray <= '0;
      rd_valid    <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      full        <= full_nxt;
      empty       <= empty_nxt;
      wr_ptr_gray <= wr_ptr_nxt ^ (wr_ptr_nxt >> 1);
      rd_ptr_gray <= rd_ptr_nxt ^ (rd_ptr_nxt >> 1);
      rd_valid    <= ram_re;
      overflow    <= wr_req & full;
      underflow   <= rd_req & empty;
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_nxt >= PW'(AF_LEVEL));
      almost_empty <= (count_nxt <= PW'(AE_LEVEL));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb/tb_fifo_ptr_ctrl.sv - self-checking bench for fifo_ptr_ctrl (ADDR_W=4)
// Reference model tracks total accepted pushes/pops; occupancy and pointers derive from those.
module tb_fifo_ptr_ctrl;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic              wr_req;
  logic              rd_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   wr_ptr_gray;
  logic [ADDR_W:0]   rd_ptr_gray;
  logic              overflow;
  logic              underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic              almost_full;
  logic              almost_empty;
`endif

  fifo_ptr_ctrl #(.ADDR_W(ADDR_W), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .ram_we      (ram_we),
    .ram_waddr   (ram_waddr),
    .ram_re      (ram_re),
    .ram_raddr   (ram_raddr),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .overflow    (overflow),
    .underflow   (underflow)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full (almost_full),
    .almost_empty(almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state: totals of accepted operations since reset
  int  m_wtot;
  int  m_rtot;
  bit  m_rv;
  bit  m_ovf;
  bit  m_unf;

  typedef struct {
    bit wr;
    bit rd;
    int exp_count;
    bit exp_full;
    bit exp_empty;
    bit exp_ovf;
    bit exp_unf;
    bit exp_rv;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray_of(input int ptr);
    int p;
    p = ptr % (2 * DEPTH);
    return p ^ (p >> 1);
  endfunction

  task automatic model_reset();
    m_wtot = 0;
    m_rtot = 0;
    m_rv   = 0;
    m_ovf  = 0;
    m_unf  = 0;
  endtask

  task automatic check_regs(input string tag);
    int occ;
    occ = m_wtot - m_rtot;
    chk({tag, " count"}, 32'(count), occ);
    chk({tag, " full"}, 32'(full), (occ == DEPTH) ? 1 : 0);
    chk({tag, " empty"}, 32'(empty), (occ == 0) ? 1 : 0);
    chk({tag, " wr_gray"}, 32'(wr_ptr_gray), gray_of(m_wtot));
    chk({tag, " rd_gray"}, 32'(rd_ptr_gray), gray_of(m_rtot));
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'(m_rv));
    chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(m_unf));
`ifdef FIFO_ALMOST_FLAGS_EN
    chk({tag, " almost_full"}, 32'(almost_full), (occ >= 12) ? 1 : 0);
    chk({tag, " almost_empty"}, 32'(almost_empty), (occ <= 4) ? 1 : 0);
`endif
  endtask

  // One clock: drive inputs, check strobes/addresses, advance model, check registered outputs.
  task automatic cycle(input bit wr, input bit rd, input string tag);
    int occ;
    bit we_e;
    bit re_e;
    wr_req = wr;
    rd_req = rd;
    #1;
    occ  = m_wtot - m_rtot;
    we_e = wr && (occ < DEPTH);
    re_e = rd && (occ > 0);
    chk({tag, " ram_we"}, 32'(ram_we), 32'(we_e));
    chk({tag, " ram_re"}, 32'(ram_re), 32'(re_e));
    chk({tag, " ram_waddr"}, 32'(ram_waddr), m_wtot % DEPTH);
    chk({tag, " ram_raddr"}, 32'(ram_raddr), m_rtot % DEPTH);
    @(posedge clk);
    if (we_e) m_wtot++;
    if (re_e) m_rtot++;
    m_ovf = wr && !we_e;
    m_unf = rd && !re_e;
    m_rv  = re_e;
    #1;
    check_regs(tag);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    check_regs({tag, " async"});
    @(posedge clk);
    #1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    rst    = 1'b0;
    check_regs(tag);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{wr:0, rd:1, exp_count:0, exp_full:0, exp_empty:1, exp_ovf:0, exp_unf:1, exp_rv:0};
    vecs[1] = '{wr:1, rd:1, exp_count:1, exp_full:0, exp_empty:0, exp_ovf:0, exp_unf:1, exp_rv:0};
    vecs[2] = '{wr:1, rd:0, exp_count:2, exp_full:0, exp_empty:0, exp_ovf:0, exp_unf:0, exp_rv:0};
    vecs[3] = '{wr:1, rd:1, exp_count:2, exp_full:0, exp_empty:0, exp_ovf:0, exp_unf:0, exp_rv:1};
    vecs[4] = '{wr:0, rd:1, exp_count:1, exp_full:0, exp_empty:0, exp_ovf:0, exp_unf:0, exp_rv:1};
    vecs[5] = '{wr:0, rd:1, exp_count:0, exp_full:0, exp_empty:1, exp_ovf:0, exp_unf:0, exp_rv:1};
    vecs[6] = '{wr:0, rd:0, exp_count:0, exp_full:0, exp_empty:1, exp_ovf:0, exp_unf:0, exp_rv:0};
    vecs[7] = '{wr:1, rd:0, exp_count:1, exp_full:0, exp_empty:0, exp_ovf:0, exp_unf:0, exp_rv:0};
    vecs[8] = '{wr:0, rd:1, exp_count:0, exp_full:0, exp_empty:1, exp_ovf:0, exp_unf:0, exp_rv:1};

    rst    = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset count", 32'(count), 0);
    chk("reset empty", 32'(empty), 1);
    chk("reset full", 32'(full), 0);
    chk("reset wr_gray", 32'(wr_ptr_gray), 0);
    chk("reset rd_gray", 32'(rd_ptr_gray), 0);
    chk("reset overflow", 32'(overflow), 0);
    chk("reset underflow", 32'(underflow), 0);
    chk("reset rd_valid", 32'(rd_valid), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].wr, vecs[i].rd, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl count", i), 32'(count), vecs[i].exp_count);
      chk($sformatf("vec%0d tbl full", i), 32'(full), 32'(vecs[i].exp_full));
      chk($sformatf("vec%0d tbl empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d tbl overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d tbl underflow", i), 32'(underflow), 32'(vecs[i].exp_unf));
      chk($sformatf("vec%0d tbl rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_rv));
    end

    do_reset("rst_fill");
    for (int i = 0; i < 16; i++) begin
      wr_req = 1'b1;
      rd_req = 1'b0;
      #1;
      chk($sformatf("fill waddr%0d", i), 32'(ram_waddr), i);
      cycle(1, 0, "fill");
    end
    chk("fill full", 32'(full), 1);
    chk("fill count", 32'(count), 16);
    chk("fill wr_gray", 32'(wr_ptr_gray), 32'h18);
    cycle(1, 0, "write17");
    chk("write17 overflow", 32'(overflow), 1);
    chk("write17 count", 32'(count), 16);
    cycle(0, 0, "idle_after_ovf");
    chk("overflow not sticky", 32'(overflow), 0);

    cycle(1, 1, "full_wr_rd");
    chk("full_wr_rd count", 32'(count), 15);
    chk("full_wr_rd overflow", 32'(overflow), 1);

    for (int i = 0; i < 15; i++) cycle(0, 1, "drain");
    cycle(1, 1, "empty_wr_rd");
    chk("empty_wr_rd count", 32'(count), 1);
    chk("empty_wr_rd underflow", 32'(underflow), 1);

    for (int i = 0; i < 7; i++) cycle(1, 0, "to8");
    chk("at8 count", 32'(count), 8);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, "steady8");
      chk("steady8 count", 32'(count), 8);
      chk("steady8 rd_valid", 32'(rd_valid), 1);
    end

    for (int i = 0; i < 8; i++) cycle(0, 1, "drain8");
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, "wrap_w");
      cycle(0, 1, "wrap_r");
      chk("wrap empty", 32'(empty), 1);
    end

    do_reset("rst_rand");
    for (int i = 0; i < 600; i++) begin
      int pw;
      int ph;
      ph = (i / 60) % 3;
      pw = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
      cycle(($urandom_range(99) < pw), ($urandom_range(99) < (100 - pw)), "rand");
    end

    do_reset("rst_burst");
    for (int i = 0; i < 9; i++) cycle(1, 0, "burst");
    chk("burst count9", 32'(count), 9);
    wr_req = 1'b1;
    do_reset("rst_mid");
    chk("rst_mid count", 32'(count), 0);
    chk("rst_mid empty", 32'(empty), 1);
    cycle(1, 0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
